i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
I2C target (slave) endpoint sitting directly downstream of i2c_master on the same board-level SCL/SDA pair.
- Oversamples SCL/SDA on the system clock.
- Detects START/STOP and matches a 7-bit address.
- Receives write bytes and supplies read bytes to local logic over a simple strobe interface.
- Drives SDA open-drain style: 0 = pull low, 1 = release. The bench wired-ANDs it with the master's o_sda and feeds the result back as the master's i_sda.

Parameters:
SLV_ADDR, 7'h42, 7-bit address this target responds to.
SYNC_STAGES, 2, flops in each SCL/SDA input synchroniser (minimum 2).

Ports:
clk  input  1  system clock, same domain as i2c_master.
rst_n  input  1  asynchronous active-low reset.
i_scl  input  1  bus SCL (wired-AND of all drivers).
i_sda  input  1  bus SDA (wired-AND of all drivers).
o_sda  output  1  SDA drive: 0 pulls low, 1 releases.
rx_data  output  8  last byte written by master.
rx_valid  output  1  one-cycle strobe; rx_data is new.
tx_data  input  8  byte to return on a master read.
tx_req  output  1  one-cycle strobe requesting the next tx_data.
addr_hit  output  1  high from address ACK until STOP or repeated START.
rw_dir  output  1  R/W bit of the current transfer (1 = read); valid while addr_hit.
busy  output  1  high from START detect until STOP detect.

Behaviour:
- Reset values: o_sda=1, rx_data=0, rx_valid=0, tx_req=0, addr_hit=0, rw_dir=0, busy=0, state=IDLE, bit count=7. Reset is asynchronous: o_sda releases in the same instant rst_n falls.
- Input path: SCL and SDA each pass through SYNC_STAGES flops plus one history flop.
  - scl_rise / scl_fall are single-cycle strobes on the synchronised values.
  - START = synchronised SDA 1->0 while SCL high. STOP = SDA 0->1 while SCL high.
  - Latency from pin to event: SYNC_STAGES+1 clk.
- Sampling: data bits are sampled on scl_rise, MSB first. o_sda changes only on scl_fall, or on START/STOP (which always release).
- States:
  - IDLE: SDA released. START -> ADDR.
  - ADDR: shift 8 bits (7 address + R/W). After bit 0:
    - address == SLV_ADDR -> ADDR_ACK.
    - otherwise -> WAIT_STOP.
  - ADDR_ACK: on the scl_fall after bit 0, drive o_sda=0; set addr_hit=1 and rw_dir. Release on the next scl_fall. Then:
    - rw_dir=0 -> RX_DATA.
    - rw_dir=1 -> TX_DATA. tx_req pulses on the scl_rise of the ACK bit; tx_data is latched into the shift register on the ACK-ending scl_fall, and bit 7 is driven on that same edge.
  - RX_DATA: shift 8 bits. After bit 0, update rx_data and pulse rx_valid on that scl_rise, then -> RX_ACK.
  - RX_ACK: drive 0 for one SCL period, exactly as in ADDR_ACK. Every byte is ACKed. -> RX_DATA.
  - TX_DATA: drive shift-register MSB on each scl_fall. After 8 bits, release SDA on the following scl_fall -> TX_ACK.
  - TX_ACK: sample the master ACK on scl_rise.
    - 0 (ACK): pulse tx_req, reload on the next scl_fall -> TX_DATA.
    - 1 (NACK): -> WAIT_STOP.
  - WAIT_STOP: SDA released; waits for STOP or START.
- Global overrides, valid from any state:
  - STOP -> IDLE, with addr_hit=0 and busy=0.
  - START (repeated start) -> ADDR, with bit count=7 and addr_hit=0.
  - Both override the bit/ACK logic in the same cycle.
- Bit counter: 3 bits, counts 7 down to 0 and wraps to 7 on entry to each byte.
- If START and scl_rise are detected in the same cycle, START wins.
- A bus held idle (SCL=1, SDA=1) produces no events, regardless of duration.

Optional Feature:
I2C_GLITCH_FILTER_EN
- Defined: after synchronisation, each of SCL/SDA passes a 3-sample filter. The filtered value changes only when 3 consecutive samples agree. Pulses of 2 clk or shorter are suppressed, and event latency grows by 2 clk.
- Undefined: no filter; latency is SYNC_STAGES+1.

Test Plan:
- i2c_master write of address byte 0x84 (0x42, W) then data 0xA5 -> target ACKs both; rx_data=0xA5 with a single rx_valid pulse; addr_hit=1 until STOP; busy falls after STOP.
- Address byte 0x86 (0x43, W) -> no ACK (SDA stays 1 in the ACK slot); state WAIT_STOP; no rx_valid; busy=1 until STOP.
- Read: address byte 0x85, tx_data=0x3C, master ACK, then tx_data=0xC3, master NACK -> bus carries 0x3C then 0xC3; exactly 2 tx_req pulses; SDA released after the NACK.
- Repeated START issued mid-RX_DATA after 4 bits, then address 0x85 -> partial byte discarded (no rx_valid); read phase proceeds; rw_dir=1.
- rst_n asserted while target drives the ACK low -> o_sda=1 immediately (asynchronous); all outputs return to reset values; next transaction completes normally.
- With I2C_GLITCH_FILTER_EN: inject a 1-clk low glitch on SDA while SCL high during IDLE -> no START detected; busy stays 0.

Source files
------------

// File: rtl/i2c_target_if.sv
// I2C target bus/local-side signal bundle: SCL/SDA pins plus the byte strobe interface.
// Latency: none (wires only).
// Backpressure: none; tx_req/rx_valid are one-cycle strobes with no ready handshake.
// Ports:
//   i_scl, i_sda   bus lines as seen on the board (wired-AND of all drivers)
//   o_sda          target SDA drive, 0 pulls low, 1 releases
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   tx_data/tx_req    byte to send on a read and the strobe asking for the next one
//   addr_hit, rw_dir, busy  transfer status
interface i2c_target_if;
    logic       i_scl;
    logic       i_sda;
    logic       o_sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addr_hit;
    logic       rw_dir;
    logic       busy;

    modport slave (
        input  i_scl, i_sda, tx_data,
        output o_sda, rx_data, rx_valid, tx_req, addr_hit, rw_dir, busy
    );

    modport master (
        output i_scl, i_sda, tx_data,
        input  o_sda, rx_data, rx_valid, tx_req, addr_hit, rw_dir, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detect, 7-bit address match, byte RX/TX.
// Latency: pin to event SYNC_STAGES+1 clk (+2 clk when I2C_GLITCH_FILTER_EN is defined).
// Backpressure: none; every written byte is ACKed, tx_data must be valid by the next SCL fall after tx_req.
// Ports: clk, rst_n (async active-low), bus (i2c_target_if.slave: i_scl, i_sda, o_sda, rx_data,
//   rx_valid, tx_data, tx_req, addr_hit, rw_dir, busy).
// Optional feature macro: I2C_GLITCH_FILTER_EN adds a 3-sample agreement filter on SCL/SDA.
module i2c_target #(
    parameter logic [6:0] SLV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_target_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    // Input synchronisers
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_s, sda_s;   // synchronised
    logic                   scl_f, sda_f;   // after optional filter
    logic                   scl_h_q, scl_h_d, sda_h_q, sda_h_d;

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;
`endif

    // Event strobes
    logic scl_rise, scl_fall, start_det, stop_det;

    // FSM and datapath
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       phase_q, phase_d;       // second half of an ACK/reload slot
    logic       o_sda_q, o_sda_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       addr_hit_q, addr_hit_d;
    logic       rw_dir_q, rw_dir_d;
    logic       busy_q, busy_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.i_scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.i_sda};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
        // The filtered value follows the input only once the current and two previous
        // samples agree; otherwise it holds, and the held value is the history flop.
        scl_flt_d = {scl_flt_q[0], scl_s};
        sda_flt_d = {sda_flt_q[0], sda_s};
        scl_f = (scl_s == scl_flt_q[0] && scl_s == scl_flt_q[1]) ? scl_s : scl_h_q;
        sda_f = (sda_s == sda_flt_q[0] && sda_s == sda_flt_q[1]) ? sda_s : sda_h_q;
`else
        scl_f = scl_s;
        sda_f = sda_s;
`endif

        scl_h_d   = scl_f;
        sda_h_d   = sda_f;
        scl_rise  =  scl_f & ~scl_h_q;
        scl_fall  = ~scl_f &  scl_h_q;
        // SCL must be high in both samples so an SCL edge never looks like START/STOP.
        start_det = scl_f & scl_h_q &  sda_h_q & ~sda_f;
        stop_det  = scl_f & scl_h_q & ~sda_h_q &  sda_f;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        o_sda_d    = o_sda_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        addr_hit_d = addr_hit_q;
        rw_dir_d   = rw_dir_q;
        busy_d     = busy_q;

        if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = 3'd7;
            phase_d    = 1'b0;
            o_sda_d    = 1'b1;
            addr_hit_d = 1'b0;
            busy_d     = 1'b1;
        end else if (stop_det) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd7;
            phase_d    = 1'b0;
            o_sda_d    = 1'b1;
            addr_hit_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE, WAIT_STOP: ;

                ADDR: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_f};
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd7;
                        state_d   = (shift_d[7:1] == SLV_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            o_sda_d    = 1'b0;
                            phase_d    = 1'b1;
                            addr_hit_d = 1'b1;
                            rw_dir_d   = shift_q[0];
                        end else begin
                            phase_d = 1'b0;
                            if (rw_dir_q) begin
                                // Load the first read byte and put its MSB on the bus at once.
                                shift_d = bus.tx_data;
                                o_sda_d = bus.tx_data[7];
                                state_d = TX_DATA;
                            end else begin
                                o_sda_d = 1'b1;
                                state_d = RX_DATA;
                            end
                        end
                    end else if (scl_rise && phase_q && rw_dir_q) begin
                        tx_req_d = 1'b1;
                    end
                end

                RX_DATA: if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_f};
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d  = 3'd7;
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = RX_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end

                RX_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        o_sda_d = 1'b0;
                        phase_d = 1'b1;
                    end else begin
                        o_sda_d = 1'b1;
                        phase_d = 1'b0;
                        state_d = RX_DATA;
                    end
                end

                TX_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        o_sda_d   = 1'b1;
                        bit_cnt_d = 3'd7;
                        state_d   = TX_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        o_sda_d   = shift_q[6];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end

                TX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_f) begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && phase_q) begin
                        shift_d = bus.tx_data;
                        o_sda_d = bus.tx_data[7];
                        phase_d = 1'b0;
                        state_d = TX_DATA;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Sync chains reset to the idle-bus level so reset release creates no START/STOP.
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
`ifdef I2C_GLITCH_FILTER_EN
            scl_flt_q  <= 2'b11;
            sda_flt_q  <= 2'b11;
`endif
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= 8'h00;
            phase_q    <= 1'b0;
            o_sda_q    <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            rw_dir_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_h_q    <= scl_h_d;
            sda_h_q    <= sda_h_d;
`ifdef I2C_GLITCH_FILTER_EN
            scl_flt_q  <= scl_flt_d;
            sda_flt_q  <= sda_flt_d;
`endif
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            o_sda_q    <= o_sda_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            addr_hit_q <= addr_hit_d;
            rw_dir_q   <= rw_dir_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_sda    = o_sda_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.addr_hit = addr_hit_q;
    assign bus.rw_dir   = rw_dir_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, scoreboard queues for received and read-back bytes.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_target;
    localparam int Q = 8;   // clk per quarter SCL period

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;

    always #5 clk = ~clk;

    i2c_target_if bus();
    assign bus.i_scl   = m_scl;
    assign bus.i_sda   = m_sda & bus.o_sda;
    assign bus.tx_data = tx_data;

    i2c_target #(.SLV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    int treq_cnt = 0;
    logic [7:0] exp_rx[$];   // bytes the target must report on rx_valid
    logic [7:0] tx_src[$];   // bytes handed to the target on each tx_req
    logic [7:0] txn_dat[$];  // payload for the next transaction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT strobes.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.rx_valid === 1'b1) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                total++; bad++;
                $display("FAIL rx_unexpected: got %0h expected no byte", bus.rx_data);
            end else begin
                check("rx_data", bus.rx_data, exp_rx.pop_front());
            end
        end
        if (rst_n && bus.tx_req === 1'b1) begin
            treq_cnt++;
            if (tx_src.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_req_unexpected: got pulse expected none");
            end else begin
                tx_data = tx_src.pop_front();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1);
    end

    task automatic qdly();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qdly();
        m_scl = 1'b1; qdly();
        m_sda = 1'b0; qdly();
        m_scl = 1'b0; qdly();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qdly();
        m_scl = 1'b1; qdly();
        m_sda = 1'b1; qdly();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    qdly();
        m_scl = 1'b1; qdly();
        qdly();
        m_scl = 1'b0; qdly();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; qdly();
        m_scl = 1'b1; qdly();
        b = bus.i_sda; qdly();
        m_scl = 1'b0; qdly();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // One complete transaction; expectations come from the address/direction rules alone.
    task automatic txn(input logic [6:0] a, input logic rw);
        logic       match;
        logic       ack;
        logic [7:0] got;
        logic [7:0] d;
        int         n, rx0, tr0;
        match = (a == 7'h42);
        n     = txn_dat.size();
        rx0   = rx_cnt;
        tr0   = treq_cnt;
        if (rw && match)
            foreach (txn_dat[i]) tx_src.push_back(txn_dat[i]);
        i2c_start();
        check("busy_after_start", bus.busy, 1);
        write_byte({a, rw}, ack);
        check("addr_ack", ack, !match);
        for (int i = 0; i < n; i++) begin
            d = txn_dat[i];
            if (!rw) begin
                if (match) exp_rx.push_back(d);
                write_byte(d, ack);
                check("data_ack", ack, !match);
            end else begin
                read_byte(got, i == n - 1);
                check("read_byte", got, match ? d : 8'hFF);
            end
        end
        check("addr_hit", bus.addr_hit, match);
        if (match) check("rw_dir", bus.rw_dir, rw);
        check("sda_released", bus.o_sda, 1);
        check("busy_before_stop", bus.busy, 1);
        check("rx_count", rx_cnt - rx0, (!rw && match) ? n : 0);
        check("tx_req_count", treq_cnt - tr0, (rw && match) ? n : 0);
        i2c_stop();
        qdly();
        check("busy_after_stop", bus.busy, 0);
        check("addr_hit_after_stop", bus.addr_hit, 0);
        txn_dat.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_o_sda"},    bus.o_sda,    1);
        check({tag, "_rx_data"},  bus.rx_data,  0);
        check({tag, "_rx_valid"}, bus.rx_valid, 0);
        check({tag, "_tx_req"},   bus.tx_req,   0);
        check({tag, "_addr_hit"}, bus.addr_hit, 0);
        check({tag, "_rw_dir"},   bus.rw_dir,   0);
        check({tag, "_busy"},     bus.busy,     0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] got;
        logic [7:0] ab;
        logic [6:0] a;
        logic       rw;
        int         rx0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;
        qdly();

        // Write 0xA5 to our address.
        txn_dat.push_back(8'hA5);
        txn(7'h42, 1'b0);
        check("rx_data_held", bus.rx_data, 8'hA5);

        // Wrong address: no ACK, no rx_valid, busy held until STOP.
        txn_dat.push_back(8'h11);
        txn(7'h43, 1'b0);

        // Read 0x3C (master ACK) then 0xC3 (master NACK).
        txn_dat.push_back(8'h3C);
        txn_dat.push_back(8'hC3);
        txn(7'h42, 1'b1);

        // Repeated START mid-byte discards the partial byte.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        check("rs_addr_ack", ack, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("rs_addr_hit_before", bus.addr_hit, 1);
        i2c_start();
        check("rs_addr_hit_cleared", bus.addr_hit, 0);
        tx_src.push_back(8'h5A);
        write_byte(8'h85, ack);
        check("rs_read_ack", ack, 0);
        read_byte(got, 1'b1);
        check("rs_read_byte", got, 8'h5A);
        check("rs_rw_dir", bus.rw_dir, 1);
        check("rs_no_rx", rx_cnt - rx0, 0);
        i2c_stop();
        qdly();

        // Asynchronous reset while the target pulls the address ACK low.
        i2c_start();
        ab = 8'h84;
        for (int i = 7; i >= 0; i--) send_bit(ab[i]);
        m_sda = 1'b1;
        qdly();
        check("ack_driven_low", bus.i_sda, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_o_sda", bus.o_sda, 1);
        repeat (2) @(posedge clk);
        #1 check_reset_vals("midrst");
        exp_rx.delete();
        tx_src.delete();
        rst_n = 1'b1;
        qdly();
        i2c_stop();
        qdly();
        txn_dat.push_back(8'h96);
        txn(7'h42, 1'b0);

`ifdef I2C_GLITCH_FILTER_EN
        // 1-clk SDA dip on an idle bus must not look like START.
        @(posedge clk); #1 m_sda = 1'b0;
        @(posedge clk); #1 m_sda = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("glitch_busy", bus.busy, 0);
`endif

        // Randomised transactions.
        for (int t = 0; t < 18; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 7'h42;
            end else begin
                a = 7'($urandom);
                if (a == 7'h42) a = 7'h13;
            end
            rw = 1'($urandom_range(0, 1));
            for (int i = 0; i < $urandom_range(1, 3); i++) txn_dat.push_back(8'($urandom));
            txn(a, rw);
        end

        check("rx_queue_drained", exp_rx.size(), 0);
        check("tx_queue_drained", tx_src.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
